// File: rtl/pattern_scan_ctrl.sv
// Round-robin arbitrated byte scanner: each granted byte is shifted MSB-first through a
// programmable Mealy sequence detector and a tagged per-byte match count is returned.
module pattern_scan_ctrl #(
    parameter int unsigned    NREQ    = 4,
    parameter int unsigned    PW      = 4,
    parameter logic [PW-1:0]  PAT_RST = 4'b1011
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [PW-1:0]     cfg_pattern,
    input  logic              cfg_overlap,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2:0]        res_id,
    output logic [3:0]        res_count,
    output logic              match_pulse,
    output logic              busy
);

    localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   pattern_q, pattern_d;
    logic            overlap_q, overlap_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]   hist_q, hist_d;
    logic [3:0]      seen_q, seen_d;
    logic [2:0]      res_id_q, res_id_d;
    logic [3:0]      res_count_q, res_count_d;
    logic            match_pulse_q, match_pulse_d;

    logic            grant_found;
    logic [IdW-1:0]  grant_idx;
    logic [7:0]      grant_byte;
    logic            cur;
    logic [PW-1:0]   window;
    logic            hit;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin : arb
        int unsigned cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % NREQ;
            if (!grant_found && req_valid[IdW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IdW'(cand);
            end
        end
    end

    always_comb begin
        grant_byte = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_idx == IdW'(i)) begin
                grant_byte = req_data[8*i +: 8];
            end
        end
    end

    // Shifting the history left keeps PW=1 well-defined: the window is then just cur.
    assign cur    = shreg_q[7];
    assign window = (hist_q << 1) | PW'(cur);
    assign hit    = (seen_q >= 4'(PW - 1)) && (window == pattern_q);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        pattern_d     = pattern_q;
        overlap_d     = overlap_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        hist_d        = hist_q;
        seen_d        = seen_q;
        res_id_d      = res_id_q;
        res_count_d   = res_count_q;
        match_pulse_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    overlap_d = cfg_overlap;
                end
                if (grant_found) begin
                    shreg_d     = grant_byte;
                    res_id_d    = 3'(grant_idx);
                    bit_cnt_d   = '0;
                    hist_d      = '0;
                    seen_d      = '0;
                    res_count_d = '0;
                    rr_ptr_d    = (grant_idx == IdW'(NREQ - 1)) ? '0 : grant_idx + IdW'(1);
                    state_d     = StShift;
                end
            end
            StShift: begin
                shreg_d       = {shreg_q[6:0], 1'b0};
                bit_cnt_d     = bit_cnt_q + 3'd1;
                match_pulse_d = hit;
                if (hit) begin
                    res_count_d = res_count_q + 4'd1;
                end
                if (!hit || overlap_q) begin
                    hist_d = window;
                    seen_d = (seen_q >= 4'(PW)) ? 4'(PW) : seen_q + 4'd1;
                end else begin
                    hist_d = '0;
                    seen_d = '0;
                end
                if (bit_cnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            pattern_q     <= PAT_RST;
            overlap_q     <= 1'b1;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            hist_q        <= '0;
            seen_q        <= '0;
            res_id_q      <= '0;
            res_count_q   <= '0;
            match_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            pattern_q     <= pattern_d;
            overlap_q     <= overlap_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            hist_q        <= hist_d;
            seen_q        <= seen_d;
            res_id_q      <= res_id_d;
            res_count_q   <= res_count_d;
            match_pulse_q <= match_pulse_d;
        end
    end

    assign req_ready   = (state_q == StIdle && grant_found) ? (NREQ'(1) << grant_idx) : '0;
    assign res_valid   = (state_q == StDone);
    assign busy        = (state_q != StIdle);
    assign res_id      = res_id_q;
    assign res_count   = res_count_q;
    assign match_pulse = match_pulse_q;

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Arbitrated serial pattern-scan controller. It accepts bytes from NREQ requesters through valid/ready handshakes and grants them round-robin. Each granted byte is serialised MSB-first through an internal programmable Mealy sequence detector, and the controller returns a per-byte match count tagged with the requester id. It sits between byte-oriented producers and the serial pattern-detection datapath, sharing one detector among all producers and owning the detector's pattern configuration.

## Interface
- NREQ, 4, number of requesters (2..8)
- PW, 4, pattern length in bits (1..8)
- PAT_RST, 4'b1011, pattern loaded at reset
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- cfg_we  in  1  configuration write strobe
- cfg_pattern  in  PW  pattern to match; bit PW-1 is the first bit received
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  NREQ*8  byte of requester i in bits [8i+7:8i]
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_id  out  3  requester index of the result
- res_count  out  4  matches found in the byte (0..8)
- match_pulse  out  1  registered one-cycle pulse per match
- busy  out  1  high in any state other than IDLE

## Operation
- States are IDLE, SHIFT and DONE.
- **IDLE**
  - busy=0.
  - If any req_valid bit is set, grant g: the first set index searching upward from rr_ptr, with wrap.
  - req_ready = one-hot(g), combinational, in this cycle only.
  - On the edge: capture req_data[g] into the shift register and g into res_id; set bit_cnt=0, hist=0, seen=0, res_count=0; set rr_ptr=(g+1) mod NREQ; go to SHIFT.
  - With no valid requests, stay in IDLE; req_ready=0.
- **SHIFT** (8 cycles)
  - Each cycle, cur = the shift register MSB, and the shift register shifts left.
  - hit = (seen>=PW-1) & ({hist[PW-2:0],cur}==pattern). When PW=1, hit = (cur==pattern).
  - On hit: res_count+1 and match_pulse<=1.
  - Otherwise: match_pulse<=0.
  - History update:
    - No hit, or cfg_overlap=1: hist<={hist,cur}, seen saturating at PW.
    - Hit with cfg_overlap=0: hist=0, seen=0.
  - After the 8th bit (bit_cnt==7), go to DONE.
- **DONE**
  - res_valid=1. res_id and res_count are held stable.
  - match_pulse<=0.
  - When res_valid & res_ready, go to IDLE.
  - req_ready=0 in SHIFT and DONE.
- Detection history never spans bytes; each byte is scanned independently.
- **Configuration**
  - cfg_we is honoured only in IDLE: pattern<=cfg_pattern, overlap<=cfg_overlap on the edge.
  - cfg_we in SHIFT or DONE is ignored and nothing is queued.
  - cfg_we in IDLE while a grant happens in the same cycle: the new config applies to that byte.
- **Reset values**
  - state=IDLE, rr_ptr=0, pattern=PAT_RST, overlap=1.
  - res_valid=0, res_id=0, res_count=0, match_pulse=0, busy=0, req_ready=0.
- Reset asserted mid-byte discards that byte. No result is produced for it.

## Timing
- Grant accepted in cycle T (IDLE).
- Bits 7..0 are processed in cycles T+1..T+8.
- match_pulse for the bit processed in cycle T+k is high during T+k+1.
- res_valid rises at T+9, together with the last possible match_pulse.
- res_valid stays high until the res_ready handshake. If res_ready=1 at T+9, IDLE is at T+10.
- Earliest next grant is T+10, so peak throughput is one byte per 10 cycles.
- res_count is final and stable whenever res_valid=1.
- rr_ptr changes only on a grant.

## Test plan
- Reset, default pattern 1011, overlap=1. Requester 0 sends 0xB6 (1011_0110), res_ready=1. Expected:
  - req_ready[0] in the accept cycle.
  - match_pulse high at T+5 and T+8.
  - res_valid at T+9 with res_id=0, res_count=2.
- Same byte 0xB6 with cfg_overlap=0 written in IDLE -> res_count=1, single match_pulse at T+5. Byte 0xBB -> res_count=2 in both modes.
- req_valid=4'b0101 held continuously, res_ready=1 -> grant order 0,2,0,2; each grant is 10 cycles after the previous one; res_id follows the same order.
- res_ready held 0 for 5 cycles after res_valid rises. Expected:
  - res_valid, res_id and res_count are stable.
  - busy=1 and req_ready=0 throughout.
  - Grant occurs the cycle after the handshake completes.
- cfg_we with pattern 4'b0000 during SHIFT is ignored: the current and next byte (0xB6) both give count 2. The same write in IDLE, then byte 0x00, gives count 5 with overlap=1.
- reset deasserted→asserted at T+4 of a byte. Expected:
  - All outputs go to their reset values immediately.
  - No res_valid for the discarded byte.
  - After release, the first grant goes to the lowest-indexed valid requester (rr_ptr=0), and the pattern reverts to 1011.
